frame_writer: RTL and testbench

Fills the 300x300 8-bit grayscale frame memory that the VGA pixel printer scans out. It accepts a valid/ready pixel byte stream (processor or UART side) and issues write strobes to the memory's write port. Addresses cover the same window the printer reads, base 324 through 90323 in raster order. It runs in the vga_clk domain and is the write-side counterpart of the scan-out path.

---
 rtl/vga_pkg.sv | 19 +
 rtl/frame_writer_raster_counter.sv | 65 ++++++
 rtl/frame_writer.sv | 116 +++++++++++
 tb/tb_frame_writer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Frame geometry, bus widths and writer FSM encoding shared by the
// frame writer and the VGA pixel printer.
package vga_pkg;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 8;
    localparam int POS_W     = 9;
    localparam int BASE_ADDR = 324;
    localparam int FRAME_W   = 300;
    localparam int FRAME_H   = 300;
    localparam int LAST_ADDR = BASE_ADDR + FRAME_W * FRAME_H - 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } writer_state_t;

endpackage

// File: rtl/frame_writer_raster_counter.sv
// Raster position tracker: column, row and the frame-memory address of the
// next pixel, with clear (priority) and increment, plus a last-pixel flag.
module raster_counter
    import vga_pkg::*;
#(
    parameter int BASE_ADDR = vga_pkg::BASE_ADDR,
    parameter int WIDTH     = vga_pkg::FRAME_W,
    parameter int HEIGHT    = vga_pkg::FRAME_H,
    parameter int ADDR_W    = vga_pkg::ADDR_W
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [POS_W-1:0]  col,
    output logic [POS_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [POS_W-1:0]  col_q, col_d;
    logic [POS_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              end_of_row;

    assign end_of_row = (col_q == POS_W'(WIDTH - 1));

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (clr) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = ADDR_W'(BASE_ADDR);
        end else if (inc) begin
            // Addresses are contiguous across row boundaries: no line padding.
            addr_d = addr_q + ADDR_W'(1);
            if (end_of_row) begin
                col_d = '0;
                row_d = row_q + POS_W'(1);
            end else begin
                col_d = col_q + POS_W'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign addr = addr_q;
    assign last = end_of_row && (row_q == POS_W'(HEIGHT - 1));

endmodule

// File: rtl/frame_writer.sv
// Write side of the VGA frame memory: turns a valid/ready pixel stream into
// registered write strobes covering one raster-ordered frame per start.
module frame_writer
    import vga_pkg::*;
#(
    parameter int BASE_ADDR = vga_pkg::BASE_ADDR,
    parameter int WIDTH     = vga_pkg::FRAME_W,
    parameter int HEIGHT    = vga_pkg::FRAME_H,
    parameter int ADDR_W    = vga_pkg::ADDR_W,
    parameter int DATA_W    = vga_pkg::DATA_W
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic [8:0]        col,
    output logic [8:0]        row
);

    writer_state_t     state_q, state_d;
    logic              accept;
    logic              cnt_inc;
    logic              cnt_clr;
    logic              last_px;
    logic [ADDR_W-1:0] next_addr;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    raster_counter #(
        .BASE_ADDR (BASE_ADDR),
        .WIDTH     (WIDTH),
        .HEIGHT    (HEIGHT),
        .ADDR_W    (ADDR_W)
    ) u_raster (
        .vga_clk (vga_clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .col     (col),
        .row     (row),
        .addr    (next_addr),
        .last    (last_px)
    );

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WRITE;
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && last_px) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort wins over a same-cycle handshake, so that beat is never written.
    always_comb begin
        s_ready      = (state_q == WRITE);
        accept       = s_ready && s_valid && !abort;
        cnt_inc      = accept;
        cnt_clr      = ((state_q == IDLE) && start) || (s_ready && abort) || (accept && last_px);
        wr_en_d      = accept;
        wr_addr_d    = accept ? next_addr : wr_addr_q;
        wr_data_d    = accept ? s_data : wr_data_q;
        frame_done_d = accept && last_px;
        busy_d       = (state_d == WRITE);
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= ADDR_W'(BASE_ADDR);
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_writer.sv
// Randomised bench for frame_writer against a pixel-index reference model,
// on a scaled-down frame so that complete frames stay short.
module tb_frame_writer;

    localparam int BASE  = 324;
    localparam int W     = 20;
    localparam int H     = 15;
    localparam int NPIX  = W * H;
    localparam int LIMIT = 20 * NPIX;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_DONE = 2;

    logic        vga_clk = 1'b0;
    logic        rst     = 1'b0;
    logic        start   = 1'b0;
    logic        abort   = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data  = 8'h00;
    logic        s_ready;
    logic        wr_en;
    logic [17:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        frame_done;
    logic [8:0]  col;
    logic [8:0]  row;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame phase plus index of the next pixel to accept.
    int          m_phase;
    int          m_n;
    logic        e_wr_en;
    logic        e_done;
    logic [17:0] e_wr_addr;
    logic [7:0]  e_wr_data;

    int          n_writes;
    int          n_done;
    logic [17:0] first_addr;

    frame_writer #(
        .BASE_ADDR (BASE),
        .WIDTH     (W),
        .HEIGHT    (H),
        .ADDR_W    (18),
        .DATA_W    (8)
    ) dut (
        .vga_clk    (vga_clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .col        (col),
        .row        (row)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 25) begin
                $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
            end
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_n       = 0;
        e_wr_en   = 1'b0;
        e_done    = 1'b0;
        e_wr_addr = 18'(BASE);
        e_wr_data = 8'h00;
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, "_wr_en"}, 32'(wr_en), 32'(e_wr_en));
        check_eq({pfx, "_wr_addr"}, 32'(wr_addr), 32'(e_wr_addr));
        if (e_wr_en) check_eq({pfx, "_wr_data"}, 32'(wr_data), 32'(e_wr_data));
        check_eq({pfx, "_frame_done"}, 32'(frame_done), 32'(e_done));
        check_eq({pfx, "_busy"}, 32'(busy), 32'(m_phase == PH_LOAD));
        check_eq({pfx, "_col"}, 32'(col), 32'(m_n % W));
        check_eq({pfx, "_row"}, 32'(row), 32'(m_n / W));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_outputs("rst");
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge vga_clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: inputs were set after the previous edge; model sees the same values.
    task automatic tick();
        bit acc;
        @(negedge vga_clk);
        check_eq("s_ready", 32'(s_ready), 32'(m_phase == PH_LOAD));
        acc     = (m_phase == PH_LOAD) && s_valid && !abort;
        e_wr_en = acc;
        e_done  = 1'b0;
        case (m_phase)
            PH_IDLE: if (start) begin
                m_phase = PH_LOAD;
                m_n     = 0;
            end
            PH_LOAD: begin
                if (abort) begin
                    m_phase = PH_IDLE;
                    m_n     = 0;
                end else if (acc) begin
                    e_wr_addr = 18'(BASE + m_n);
                    e_wr_data = s_data;
                    if (m_n == NPIX - 1) begin
                        e_done  = 1'b1;
                        m_phase = PH_DONE;
                        m_n     = 0;
                    end else begin
                        m_n++;
                    end
                end
            end
            default: m_phase = PH_IDLE;
        endcase
        @(posedge vga_clk);
        #1;
        check_outputs("cyc");
        if (wr_en) begin
            if (n_writes == 0) first_addr = wr_addr;
            n_writes++;
        end
        if (frame_done) n_done++;
    endtask

    task automatic run_frame(input int gap_pct, input bit seq_data, input int restart_a,
                             input int restart_b, input int abort_at, input int rst_at);
        int budget;
        bit stop;
        budget     = 0;
        stop       = 1'b0;
        n_writes   = 0;
        n_done     = 0;
        first_addr = '0;
        s_valid    = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        while (m_phase == PH_LOAD && !stop && budget < LIMIT) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = seq_data ? m_n[7:0] : 8'($urandom);
            start   = (m_n == restart_a) || (m_n == restart_b);
            abort   = (m_n == abort_at);
            if (abort) s_valid = 1'b1;
            if (m_n == rst_at) begin
                apply_reset();
                stop = 1'b1;
            end else begin
                tick();
                budget++;
            end
        end
        check_eq("frame_budget", 32'(budget < LIMIT), 32'd1);
        abort   = 1'b0;
        s_valid = 1'b1;
        start   = (m_phase == PH_DONE) ? 1'($urandom_range(1)) : 1'b0;
        tick();
        start   = 1'b0;
        s_valid = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        apply_reset();

        // Idle with valid data and stray abort: nothing may be consumed.
        n_writes = 0;
        s_valid  = 1'b1;
        s_data   = 8'hA5;
        repeat (8) tick();
        abort = 1'b1;
        repeat (2) tick();
        abort   = 1'b0;
        s_valid = 1'b0;
        check_eq("idle_writes", 32'(n_writes), 32'd0);

        // Back-to-back full frame with index-valued data.
        run_frame(0, 1'b1, -1, -1, -1, -1);
        check_eq("b2b_writes", 32'(n_writes), 32'(NPIX));
        check_eq("b2b_done", 32'(n_done), 32'd1);
        check_eq("b2b_first", 32'(first_addr), 32'(BASE));
        check_eq("b2b_last", 32'(wr_addr), 32'(BASE + NPIX - 1));

        // Full frame with ~30% source bubbles.
        run_frame(30, 1'b0, -1, -1, -1, -1);
        check_eq("gap_writes", 32'(n_writes), 32'(NPIX));
        check_eq("gap_done", 32'(n_done), 32'd1);
        check_eq("gap_last", 32'(wr_addr), 32'(BASE + NPIX - 1));

        // Abort together with the handshake of beat 100.
        run_frame(20, 1'b0, -1, -1, 100, -1);
        check_eq("abort_writes", 32'(n_writes), 32'd100);
        check_eq("abort_done", 32'(n_done), 32'd0);
        check_eq("abort_last", 32'(wr_addr), 32'(BASE + 99));
        run_frame(10, 1'b0, -1, -1, -1, -1);
        check_eq("restart_first", 32'(first_addr), 32'(BASE));
        check_eq("restart_writes", 32'(n_writes), 32'(NPIX));
        check_eq("restart_done", 32'(n_done), 32'd1);

        // start re-pulsed mid-load must not restart.
        run_frame(15, 1'b0, 10, 200, -1, -1);
        check_eq("repulse_writes", 32'(n_writes), 32'(NPIX));
        check_eq("repulse_done", 32'(n_done), 32'd1);

        // Reset in the middle of row 7, then a clean frame.
        run_frame(10, 1'b0, -1, -1, -1, 7 * W + 5);
        check_eq("rst_no_done", 32'(n_done), 32'd0);
        run_frame(0, 1'b1, -1, -1, -1, -1);
        check_eq("post_rst_writes", 32'(n_writes), 32'(NPIX));
        check_eq("post_rst_done", 32'(n_done), 32'd1);
        check_eq("post_rst_first", 32'(first_addr), 32'(BASE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
